// File: rtl/vga_plot_arbiter_pkg.sv
// Shared types and screen constants for the VGA pixel-port arbiter and its picker.
package vga_plot_arbiter_pkg;

    localparam int unsigned SCREEN_W        = 160;
    localparam int unsigned SCREEN_H        = 120;
    localparam int unsigned SCREEN_X_W      = 8;
    localparam int unsigned SCREEN_Y_W      = 7;
    localparam int unsigned SCREEN_COLOUR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above the pointer, wrapping.
module vga_plot_arbiter_rr_pick
    import vga_plot_arbiter_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt_c,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_any_c
);

    always_comb begin
        int unsigned j;
        o_gnt_c = '0;
        o_idx_c = '0;
        o_any_c = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(i_ptr) + k;
            if (j >= N) j = j - N;
            if (!o_any_c && i_req[j]) begin
                o_any_c    = 1'b1;
                o_gnt_c[j] = 1'b1;
                o_idx_c    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the single VGA adapter pixel-write port, with burst hold timeout.
module vga_plot_arbiter
    import vga_plot_arbiter_pkg::*;
#(
    parameter int unsigned N        = 3,
    parameter int unsigned X_W      = SCREEN_X_W,
    parameter int unsigned Y_W      = SCREEN_Y_W,
    parameter int unsigned COLOUR_W = SCREEN_COLOUR_W,
    parameter int unsigned MAX_HOLD = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N-1:0]            i_req,
    input  logic [N-1:0]            i_done,
    input  logic [N-1:0]            i_plot,
    input  logic [N*X_W-1:0]        i_x,
    input  logic [N*Y_W-1:0]        i_y,
    input  logic [N*COLOUR_W-1:0]   i_colour,
    output logic [N-1:0]            o_gnt,
    output logic [X_W-1:0]          o_x,
    output logic [Y_W-1:0]          o_y,
    output logic [COLOUR_W-1:0]     o_colour,
    output logic                    o_plot,
    output logic                    o_busy,
    output logic                    o_timeout
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    arb_state_e          r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_gidx, w_gidx_nxt;
    logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [N-1:0]        r_gnt, w_gnt_nxt;
    logic [X_W-1:0]      r_x, w_x_nxt;
    logic [Y_W-1:0]      r_y, w_y_nxt;
    logic [COLOUR_W-1:0] r_colour, w_colour_nxt;
    logic                r_plot, w_plot_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_timeout, w_timeout_nxt;

    logic [IDX_W-1:0]    w_ptr_inc;
    logic [IDX_W-1:0]    w_arb_ptr;
    logic [N-1:0]        w_pick_gnt;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_any;

    // Pointer that puts the just-finished grantee last; used directly while in RELEASE.
    assign w_ptr_inc = (r_gidx == IDX_LAST) ? '0 : r_gidx + 1'b1;
    assign w_arb_ptr = (r_state == ST_RELEASE) ? w_ptr_inc : r_ptr;

    vga_plot_arbiter_rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (i_req),
        .i_ptr   (w_arb_ptr),
        .o_gnt_c (w_pick_gnt),
        .o_idx_c (w_pick_idx),
        .o_any_c (w_pick_any)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_gidx_nxt    = r_gidx;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = '0;
        w_x_nxt       = '0;
        w_y_nxt       = '0;
        w_colour_nxt  = '0;
        w_plot_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_RELEASE: begin
                if (r_state == ST_RELEASE) w_ptr_nxt = w_ptr_inc;
                w_state_nxt = ST_IDLE;
                if (w_pick_any) begin
                    w_state_nxt = ST_GRANT;
                    w_gidx_nxt  = w_pick_idx;
                    w_gnt_nxt   = w_pick_gnt;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                w_x_nxt      = i_x[r_gidx*X_W +: X_W];
                w_y_nxt      = i_y[r_gidx*Y_W +: Y_W];
                w_colour_nxt = i_colour[r_gidx*COLOUR_W +: COLOUR_W];
                if (i_done[r_gidx] || !i_req[r_gidx]) begin
                    // Pixel accompanying the done is still written.
                    w_state_nxt = ST_RELEASE;
                    w_plot_nxt  = i_plot[r_gidx];
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = ST_RELEASE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_gnt_nxt  = r_gnt;
                    w_plot_nxt = i_plot[r_gidx];
                    w_cnt_nxt  = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_gidx    <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_colour  <= '0;
            r_plot    <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gidx    <= w_gidx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_colour  <= w_colour_nxt;
            r_plot    <= w_plot_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_colour  = r_colour;
    assign o_plot    = r_plot;
    assign o_busy    = r_busy;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: grants and pixels checked by a monitor against queued expectations.
module tb_vga_plot_arbiter;

    localparam int unsigned N = 3;
    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned CW = 3;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
    } pix_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    i_req, i_done, i_plot;
    logic [N*XW-1:0] i_x;
    logic [N*YW-1:0] i_y;
    logic [N*CW-1:0] i_colour;
    logic [N-1:0]    o_gnt;
    logic [XW-1:0]   o_x;
    logic [YW-1:0]   o_y;
    logic [CW-1:0]   o_colour;
    logic            o_plot, o_busy, o_timeout;

    int   total = 0;
    int   bad   = 0;
    int   tcount = 0;
    int   exp_gnt[$];
    pix_t exp_pix[$];
    logic [N-1:0] prev_gnt = '0;

    vga_plot_arbiter #(
        .N(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW), .MAX_HOLD(8)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_done(i_done), .i_plot(i_plot),
        .i_x(i_x), .i_y(i_y), .i_colour(i_colour),
        .o_gnt(o_gnt), .o_x(o_x), .o_y(o_y), .o_colour(o_colour),
        .o_plot(o_plot), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int k, input int x, input int y, input int c);
        case (k)
            0: begin i_x[7:0]   = XW'(x); i_y[6:0]   = YW'(y); i_colour[2:0] = CW'(c); end
            1: begin i_x[15:8]  = XW'(x); i_y[13:7]  = YW'(y); i_colour[5:3] = CW'(c); end
            default: begin i_x[23:16] = XW'(x); i_y[20:14] = YW'(y); i_colour[8:6] = CW'(c); end
        endcase
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(o_gnt), 0);
        chk({tag, "_x"}, 32'(o_x), 0);
        chk({tag, "_y"}, 32'(o_y), 0);
        chk({tag, "_colour"}, 32'(o_colour), 0);
        chk({tag, "_plot"}, 32'(o_plot), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_timeout"}, 32'(o_timeout), 0);
    endtask

    // Monitor: pops an expectation whenever a new grant or a pixel write appears.
    initial begin : monitor
        int   e;
        pix_t p, a;
        forever begin
            @(negedge clk);
            chk("gnt_onehot", 32'($countones(o_gnt) <= 1), 1);
            if (o_gnt != '0 && o_gnt != prev_gnt) begin
                if (exp_gnt.size() == 0) begin
                    chk("unexpected_grant", 32'(o_gnt), 0);
                end else begin
                    e = exp_gnt.pop_front();
                    chk("grant", 32'(o_gnt), 32'(1) << e);
                end
            end
            prev_gnt = o_gnt;
            if (o_timeout) tcount++;
            if (o_plot) begin
                a = '{x: o_x, y: o_y, c: o_colour};
                if (exp_pix.size() == 0) begin
                    chk("unexpected_pixel", 32'(a), 0);
                end else begin
                    p = exp_pix.pop_front();
                    chk("pixel", 32'(a), 32'(p));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench hung");
    end

    initial begin : stim
        int bursts, gcnt, gap, hold, t0;
        bit started, seen2;
        reset = 1'b1;
        i_req = '0; i_done = '0; i_plot = '0;
        i_x = '0; i_y = '0; i_colour = '0;
        repeat (2) cyc();
        chk_idle_outputs("reset");
        reset = 1'b0;

        // Single requester, then one pixel.
        i_req = 3'b010;
        exp_gnt.push_back(1);
        cyc();
        chk("t1_gnt", 32'(o_gnt), 32'b010);
        chk("t1_busy", 32'(o_busy), 1);
        i_plot = 3'b010;
        set_pix(1, 5, 7, 7);
        exp_pix.push_back('{x: 8'd5, y: 7'd7, c: 3'd7});
        cyc();
        chk("t1_plot", 32'(o_plot), 1);
        i_plot = '0;
        i_done = 3'b010;
        cyc();
        chk("t1_rel_gnt", 32'(o_gnt), 0);
        chk("t1_rel_busy", 32'(o_busy), 1);
        chk("t1_rel_timeout", 32'(o_timeout), 0);
        i_done = '0;
        i_req  = '0;
        cyc();
        chk("t1_idle_busy", 32'(o_busy), 0);

        // Three continuous requesters, 4-cycle bursts.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_gnt.push_back(0); exp_gnt.push_back(1);
        exp_gnt.push_back(2); exp_gnt.push_back(0);
        i_req = 3'b111;
        bursts = 0; gcnt = 0; gap = 0; started = 0;
        for (int c = 0; c < 200 && bursts < 4; c++) begin
            cyc();
            i_done = '0;
            if (o_gnt != '0) begin
                if (started && gcnt == 0) chk("t2_gap", 32'(gap), 1);
                started = 1; gap = 0; gcnt++;
                if (gcnt == 4) begin
                    i_done = o_gnt;
                    bursts++;
                    gcnt = 0;
                    if (bursts == 4) i_req = '0;
                end
            end else begin
                gap++;
            end
        end
        chk("t2_bursts", 32'(bursts), 4);
        cyc();
        i_done = '0;
        cyc();

        // Engine 0 owns the port while engine 2 tries to plot x=9.
        i_req = 3'b001;
        exp_gnt.push_back(0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            i_plot = {1'b1, 1'b0, (i != 1)};
            set_pix(0, 20 + i, i + 1, i);
            set_pix(2, 9, 9, 5);
            if (i != 1) exp_pix.push_back('{x: XW'(20 + i), y: YW'(i + 1), c: CW'(i)});
            if (i == 3) i_done = 3'b001;
            cyc();
            chk("t3_x_not9", 32'(o_x == 8'd9), 0);
        end
        i_req = '0; i_done = '0; i_plot = '0;
        cyc();
        chk("t3_idle_plot", 32'(o_plot), 0);

        // Engine 1 never finishes: forced revoke after 8 cycles, then engine 2.
        t0 = tcount;
        i_req = 3'b110;
        exp_gnt.push_back(1); exp_gnt.push_back(2);
        hold = 0; seen2 = 0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (o_gnt[1]) hold++;
            if (o_timeout) chk("t4_gnt_at_timeout", 32'(o_gnt), 0);
            if (o_gnt == 3'b100) begin
                seen2 = 1;
                i_req = '0;
                break;
            end
        end
        chk("t4_hold", 32'(hold), 8);
        chk("t4_next_is_2", 32'(seen2), 1);
        cyc();
        cyc();
        chk("t4_timeout_pulses", 32'(tcount - t0), 1);

        // Engine 0 drops its request mid-burst.
        i_req = 3'b001;
        exp_gnt.push_back(0);
        cyc();
        cyc();
        i_req = '0;
        cyc();
        chk("t5_rel_gnt", 32'(o_gnt), 0);
        chk("t5_rel_timeout", 32'(o_timeout), 0);
        chk("t5_rel_busy", 32'(o_busy), 1);
        i_req = 3'b111;
        exp_gnt.push_back(1);
        cyc();
        chk("t5_ptr_gnt", 32'(o_gnt), 32'b010);

        // Reset while a pixel is on the port.
        i_plot = 3'b010;
        set_pix(1, 33, 44, 6);
        exp_pix.push_back('{x: 8'd33, y: 7'd44, c: 3'd6});
        cyc();
        chk("t6_plot_before", 32'(o_plot), 1);
        reset = 1'b1;
        i_plot = '0;
        cyc();
        chk_idle_outputs("t6_reset");
        reset = 1'b0;
        exp_gnt.push_back(0);
        cyc();
        chk("t6_post_gnt", 32'(o_gnt), 32'b001);
        i_req = '0;
        repeat (3) cyc();

        chk("end_gnt_queue", 32'(exp_gnt.size()), 0);
        chk("end_pix_queue", 32'(exp_pix.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
